// File: rtl/servo_scheduler.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : servo_scheduler
// Brief    : Multi-channel RC-servo pulse scheduler with double-buffered
//            positions. Optional failsafe build: define SERVO_FAILSAFE_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module servo_scheduler #(
   parameter int CLK_PER_NS = 40,
   parameter int N          = 8,
   parameter int CH         = 4
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          en_i,
   input  logic          wr_valid_i,
   output logic          wr_ready_o,
   input  logic [2:0]    wr_ch_i,
   input  logic [N-1:0]  wr_pos_i,
   output logic [CH-1:0] srv_o,
   output logic          frame_o,
   output logic          fault_o
);

   localparam int c_MS_CYC    = 1_000_000 / CLK_PER_NS;
   localparam int c_STEP_CYC  = c_MS_CYC / (2 ** N);
   localparam int c_SLOT_CYC  = (5 * c_MS_CYC) / 2;
   localparam int c_FRAME_CYC = 20 * c_MS_CYC;
   localparam int c_FW        = $clog2(c_FRAME_CYC + 1);
   localparam int c_SW        = $clog2(c_SLOT_CYC + 1);
   localparam int c_CHW       = (CH > 1) ? $clog2(CH) : 1;

   localparam logic [c_CHW-1:0] c_CH_LAST   = c_CHW'(CH - 1);
   localparam logic [c_SW-1:0]  c_SLOT_LAST = c_SW'(c_SLOT_CYC - 1);
   localparam logic [c_FW-1:0]  c_FRAME_END = c_FW'(c_FRAME_CYC);

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_PULSE      = 2'd1,
      S_GAP        = 2'd2,
      S_FRAME_WAIT = 2'd3
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [c_FW-1:0]     r_frame_cnt, w_frame_cnt_nxt;
   logic [c_SW-1:0]     r_slot_cnt, w_slot_cnt_nxt;
   logic [c_CHW-1:0]    r_ch, w_ch_nxt;
   logic [CH-1:0][N-1:0] r_pending, r_active;
   logic [N-1:0]        w_act_sel;
   logic [c_SW-1:0]     w_pulse_last;
   logic [CH-1:0]       w_srv_raw;
   logic                w_frame_start;
   logic                w_wr_accept;
   logic                w_mute;

   // Frame-start cycle counts as cycle 0 of the frame and of slot 0.
   assign w_frame_start = en_i && ((r_state == S_IDLE) ||
                          ((r_state == S_FRAME_WAIT) && (r_frame_cnt == c_FRAME_END)));

   assign w_act_sel    = r_active[r_ch];
   assign w_pulse_last = c_SW'(c_MS_CYC - 1) + c_SW'(w_act_sel) * c_SW'(c_STEP_CYC);

   assign wr_ready_o  = rst_i || !w_frame_start;
   assign w_wr_accept = wr_valid_i && wr_ready_o;
   assign frame_o     = w_frame_start && !rst_i;
   assign srv_o       = (rst_i || w_mute) ? '0 : w_srv_raw;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= S_IDLE;
         r_frame_cnt <= '0;
         r_slot_cnt  <= '0;
         r_ch        <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_frame_cnt <= w_frame_cnt_nxt;
         r_slot_cnt  <= w_slot_cnt_nxt;
         r_ch        <= w_ch_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_ch_nxt        = r_ch;
      w_slot_cnt_nxt  = r_slot_cnt + c_SW'(1);
      w_frame_cnt_nxt = r_frame_cnt + c_FW'(1);
      w_srv_raw       = '0;
      if (!en_i) begin
         w_state_nxt     = S_IDLE;
         w_ch_nxt        = '0;
         w_slot_cnt_nxt  = '0;
         w_frame_cnt_nxt = '0;
      end else if (w_frame_start) begin
         w_state_nxt     = S_PULSE;
         w_ch_nxt        = '0;
         w_slot_cnt_nxt  = c_SW'(1);
         w_frame_cnt_nxt = c_FW'(1);
         w_srv_raw[0]    = 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_state_nxt = S_IDLE;
            end
            S_PULSE: begin
               w_srv_raw[r_ch] = 1'b1;
               if ((r_slot_cnt >= w_pulse_last) || (r_slot_cnt >= c_SLOT_LAST)) begin
                  w_state_nxt = S_GAP;
               end
            end
            S_GAP: begin
               if (r_slot_cnt >= c_SLOT_LAST) begin
                  w_slot_cnt_nxt = '0;
                  if (r_ch == c_CH_LAST) begin
                     w_state_nxt = S_FRAME_WAIT;
                  end else begin
                     w_state_nxt = S_PULSE;
                     w_ch_nxt    = r_ch + c_CHW'(1);
                  end
               end
            end
            S_FRAME_WAIT: begin
               w_slot_cnt_nxt = '0;
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // Writes never coincide with the frame-start copy because ready is low then.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_pending <= '0;
         r_active  <= '0;
      end else begin
         for (int k = 0; k < CH; k++) begin
            if (w_wr_accept && (wr_ch_i == 3'(k))) begin
               r_pending[k] <= wr_pos_i;
            end
         end
         if (w_frame_start) begin
            r_active <= r_pending;
         end
      end
   end

`ifdef SERVO_FAILSAFE_EN
   localparam logic [5:0] c_FS_LIMIT = 6'd50;

   logic [5:0] r_idle_frames, w_idle_frames_nxt;
   logic       r_wr_seen;
   logic       r_mute;
   logic       w_mute_frame;

   // Only frames that ran to completion are counted as silent.
   always_comb begin
      w_idle_frames_nxt = r_idle_frames;
      if (w_wr_accept) begin
         w_idle_frames_nxt = '0;
      end else if (w_frame_start && (r_state == S_FRAME_WAIT) && !r_wr_seen &&
                   (r_idle_frames != c_FS_LIMIT)) begin
         w_idle_frames_nxt = r_idle_frames + 6'd1;
      end
   end

   assign w_mute_frame = (w_idle_frames_nxt == c_FS_LIMIT);
   assign w_mute       = w_frame_start ? w_mute_frame : r_mute;
   assign fault_o      = (r_idle_frames == c_FS_LIMIT);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_idle_frames <= '0;
         r_wr_seen     <= 1'b0;
         r_mute        <= 1'b0;
      end else begin
         r_idle_frames <= w_idle_frames_nxt;
         r_wr_seen     <= w_frame_start ? 1'b0 : (r_wr_seen || w_wr_accept);
         if (w_frame_start) begin
            r_mute <= w_mute_frame;
         end
      end
   end
`else
   assign w_mute  = 1'b0;
   assign fault_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/servo_scheduler.md
SERVO_SCHEDULER -- requirements
Module: servo_scheduler

Interface
REQ-001 Parameter CLK_PER_NS, default 40: clock period in ns.
REQ-002 Parameter N, default 8: position width in bits.
REQ-003 Parameter CH, default 4: servo channel count, legal range 1..8.
REQ-004 clk_i  input  1  system clock.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 en_i  input  1  scheduler enable.
REQ-007 wr_valid_i  input  1  position write request.
REQ-008 wr_ready_o  output  1  write accept; a write transfers when wr_valid_i and wr_ready_o are both high on a clk_i rising edge.
REQ-009 wr_ch_i  input  3  target channel of the write.
REQ-010 wr_pos_i  input  N  position value of the write.
REQ-011 srv_o  output  CH  servo pulse outputs, one bit per channel.
REQ-012 frame_o  output  1  one-cycle strobe at each frame start.
REQ-013 fault_o  output  1  failsafe fault flag.

Function
REQ-014 Derived constants: MS_CYC = 1_000_000/CLK_PER_NS; STEP_CYC = MS_CYC/2^N; SLOT_CYC = (5*MS_CYC)/2; FRAME_CYC = 20*MS_CYC; all divisions are integer divisions.
REQ-015 Each channel has a pending register written by accepted transfers and an active register used for pulse generation.
REQ-016 Accepted write with wr_ch_i < CH: updates pending[wr_ch_i]. Accepted write with wr_ch_i >= CH: accepted and discarded.
REQ-017 At frame start, all active registers load from pending in a single cycle.
REQ-018 wr_ready_o is high except in the frame-start cycle, when it is low, so no write ever coincides with the active copy.
REQ-019 State machine has states IDLE, PULSE, GAP and FRAME_WAIT.
  - IDLE -> PULSE (channel 0) on the first cycle with en_i high; frame_o pulses in that cycle.
  - PULSE: srv_o[k] is high for exactly MS_CYC + active[k]*STEP_CYC cycles, then PULSE -> GAP.
  - GAP: runs to the end of slot k (SLOT_CYC cycles from slot start). Then GAP -> PULSE for k+1 if k+1 < CH, otherwise GAP -> FRAME_WAIT.
  - FRAME_WAIT: exits when FRAME_CYC cycles have elapsed since frame start, then goes to PULSE (channel 0) with frame_o and the active copy.
REQ-020 Slot k starts at cycle k*SLOT_CYC relative to frame start; at most one srv_o bit is high in any cycle.
REQ-021 Frame counter width is clog2(FRAME_CYC+1); counters never wrap within a frame.
REQ-022 en_i low in any state: next state is IDLE, counters clear, and srv_o is forced to 0 combinationally in the same cycle. Pending registers are retained and writes are still accepted.
REQ-023 en_i rising mid-period starts a fresh frame at channel 0; no partial pulse is resumed.

Reset
REQ-024 rst_i high: state IDLE, all counters 0, pending and active registers 0, srv_o 0, frame_o 0, fault_o 0, wr_ready_o 1.
REQ-025 rst_i asserted mid-pulse drops srv_o to 0 immediately, without waiting for a clock edge.

Configuration
REQ-026 Macro SERVO_FAILSAFE_EN defined:
  - A frame counter counts frames with no accepted write.
  - When the counter reaches 50, fault_o goes to 1 and srv_o is forced to 0 from that frame on.
  - The next accepted write clears fault_o and the counter; pulses resume at the next frame start.
REQ-027 Macro SERVO_FAILSAFE_EN undefined: fault_o is tied to 0 and no failsafe logic is built.

Verification (CLK_PER_NS=40, N=8, CH=4: MS_CYC=25000, STEP_CYC=97, SLOT_CYC=62500, FRAME_CYC=500000)
REQ-028 Write ch0=0, ch3=255, then raise en_i -> srv_o[0] high 25000 cycles from the frame_o cycle; srv_o[3] rises at cycle 187500 and stays high 49735 cycles; next frame_o at cycle 500000.
REQ-029 Write ch1=128 mid-frame -> the current frame keeps the old width; the next frame shows srv_o[1] high 37416 cycles.
REQ-030 wr_valid_i held high across the frame-start cycle -> wr_ready_o low for exactly 1 cycle; the write lands the following cycle.
REQ-031 Drop en_i mid-pulse on ch2 -> srv_o goes to 0 in the same cycle; re-raising en_i gives frame_o the next cycle, with ch0 pulsing first.
REQ-032 Write ch=5 value 200 -> accepted; no srv_o change on any channel.
REQ-033 With SERVO_FAILSAFE_EN: 50 frames with no writes -> fault_o=1 and srv_o=0; one write -> fault_o=0 and pulses resume at the next frame_o.
